// File: rtl/acc_pkg.sv
// ============================================================================
// Module      : acc_pkg
// Description : Shared constants and FSM state encoding for the accumulator
//               driver (acc_driver, acc_drv_gen).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_pkg;

    localparam int c_dw_default    = 32;
    localparam int c_len_w_default = 8;
    // Accumulator input-to-output latency, covered by the DRAIN state.
    localparam int c_drain_len     = 2;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_clear = 3'd1;
    localparam state_t c_st_send  = 3'd2;
    localparam state_t c_st_drain = 3'd3;
    localparam state_t c_st_done  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/acc_drv_gen.sv
// ============================================================================
// Module      : acc_drv_gen
// Description : Arithmetic word generator (base + k*step) with a running sum
//               of all issued words. Both adders wrap modulo 2^DW.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_drv_gen
    import acc_pkg::*;
#(
    parameter int DW = c_dw_default
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    input  logic [DW-1:0] base,
    input  logic [DW-1:0] step,
    output logic [DW-1:0] word,
    output logic [DW-1:0] sum
);

    logic [DW-1:0] r_word;
    logic [DW-1:0] r_step;
    logic [DW-1:0] r_sum;

    // The word is built incrementally so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= '0;
            r_step <= '0;
            r_sum  <= '0;
        end else if (load) begin
            r_word <= base;
            r_step <= step;
            r_sum  <= '0;
        end else if (advance) begin
            r_word <= r_word + r_step;
            r_sum  <= r_sum + r_word;
        end
    end

    assign word = r_word;
    assign sum  = r_sum;

endmodule

`default_nettype wire

// File: rtl/acc_driver.sv
// ============================================================================
// Module      : acc_driver
// Description : Burst driver for an accumulator: clears it, feeds len words of
//               an arithmetic sequence, waits out its latency, pulses done.
//               Optional result checker enabled by macro ACC_DRIVER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_driver
    import acc_pkg::*;
#(
    parameter int DW    = c_dw_default,
    parameter int LEN_W = c_len_w_default
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [DW-1:0]    base,
    input  logic [DW-1:0]    step,
    input  logic             hold,
    output logic             acc_clear,
    output logic             acc_enable,
    output logic [DW-1:0]    acc_data_in,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    exp_sum
`ifdef ACC_DRIVER_CHECK_EN
    ,
    input  logic [DW-1:0]    acc_data_out,
    output logic             match,
    output logic             mismatch
`endif
);

    localparam logic [1:0] c_drain_last = 2'(c_drain_len - 1);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_k;
    logic [1:0]       r_drain_cnt;

    logic             w_load;
    logic             w_advance;
    logic [DW-1:0]    w_word;

    assign w_load    = (r_state == c_st_idle) && start;
    assign w_advance = (r_state == c_st_send) && !hold;

    acc_drv_gen #(
        .DW (DW)
    ) u_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .advance (w_advance),
        .base    (base),
        .step    (step),
        .word    (w_word),
        .sum     (exp_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_len       <= '0;
            r_k         <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_len   <= len;
                        r_k     <= '0;
                        r_state <= c_st_clear;
                    end
                end
                c_st_clear: begin
                    r_drain_cnt <= '0;
                    r_state     <= (r_len == '0) ? c_st_drain : c_st_send;
                end
                c_st_send: begin
                    if (!hold) begin
                        r_k <= r_k + LEN_W'(1);
                        if (r_k == r_len - LEN_W'(1)) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (r_drain_cnt == c_drain_last) begin
                        r_drain_cnt <= '0;
                        r_state     <= c_st_done;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign acc_clear   = (r_state == c_st_clear);
    assign acc_enable  = w_advance;
    // During a hold the pending word stays on the bus with enable low.
    assign acc_data_in = (r_state == c_st_send) ? w_word : '0;

`ifdef ACC_DRIVER_CHECK_EN
    logic r_match;
    logic r_mismatch;

    always_ff @(posedge clk) begin
        if (reset || w_load) begin
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
        end else if (r_state == c_st_done) begin
            r_match    <= (acc_data_out == exp_sum);
            r_mismatch <= (acc_data_out != exp_sum);
        end
    end

    assign match    = r_match;
    assign mismatch = r_mismatch;
`endif

endmodule

`default_nettype wire

// File: doc/acc_driver.md
ACC_DRIVER -- requirements
Module: acc_driver

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data word width.
REQ-002 SHALL have parameter LEN_W, default 8, meaning burst-length field width.
REQ-003 SHALL have port clk, input, 1 bit, the clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a burst; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W bits: number of words in the burst.
REQ-007 SHALL have ports base and step, input, DW bits each: first word and increment.
REQ-008 SHALL have port hold, input, 1 bit: stall word issue while high.
REQ-009 SHALL have port acc_clear, output, 1 bit: drives the accumulator's reset.
REQ-010 SHALL have ports acc_enable (output, 1 bit) and acc_data_in (output, DW bits): the accumulator input pair.
REQ-011 SHALL have ports busy (output, 1 bit), done (output, 1 bit, single-cycle pulse) and exp_sum (output, DW bits): the expected accumulated total.

Function
REQ-012 SHALL implement the FSM states IDLE, CLEAR, SEND, DRAIN and DONE.
REQ-013 IDLE + start: SHALL latch len/base/step, zero exp_sum and the word counter, and go to CLEAR.
REQ-014 IDLE without start: SHALL stay in IDLE.
REQ-015 CLEAR: SHALL assert acc_clear for exactly 1 cycle, then go to SEND; if the latched len is 0, it SHALL go to DRAIN instead.
REQ-016 SEND, hold=0: SHALL assert acc_enable and drive acc_data_in = base + k*step mod 2^DW, where k = words already issued.
REQ-017 SEND, hold=0: SHALL add the word to exp_sum mod 2^DW and increment k.
REQ-018 SEND, hold=1: acc_enable SHALL be 0 and acc_data_in, k and exp_sum SHALL hold their values.
REQ-019 SEND: after word len-1 is issued, SHALL go to DRAIN.
REQ-020 DRAIN: SHALL last exactly 2 cycles to cover the accumulator's 2-cycle input-to-output latency, then go to DONE.
REQ-021 DONE: SHALL assert done for 1 cycle, then go to IDLE.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 start while busy SHALL be ignored, with no queueing.
REQ-024 Latency, no hold, start sampled at edge 0: acc_clear SHALL be high in cycle 1, acc_enable high in cycles 2..len+1, and done high in cycle len+4.
REQ-025 Latency, len=0: done SHALL be high in cycle 4.
REQ-026 Each hold cycle in SEND SHALL delay done by exactly 1 cycle.
REQ-027 acc_data_in SHALL be 0 whenever acc_enable is 0 outside SEND.
REQ-028 Adder overflow in the word generator and in exp_sum SHALL wrap silently.

Reset
REQ-029 reset SHALL force IDLE, and all outputs and internal registers to 0, on the next clk edge.
REQ-030 reset SHALL take priority over start, hold and any state, including mid-SEND; no done is issued for an aborted burst.

Configuration
REQ-031 With macro ACC_DRIVER_CHECK_EN defined, SHALL add input acc_data_out (DW bits) and outputs match and mismatch (1 bit each).
REQ-032 With ACC_DRIVER_CHECK_EN defined: in the DONE cycle, SHALL register match = (acc_data_out == exp_sum) and mismatch = its inverse.
REQ-033 With ACC_DRIVER_CHECK_EN defined: match and mismatch SHALL hold until the next start is accepted or reset, which clears both to 0.
REQ-034 Without ACC_DRIVER_CHECK_EN: those ports and the checker logic SHALL NOT exist; all other behaviour is identical.

Structure
REQ-035 Shared package acc_pkg SHALL hold the FSM state enumeration, the DW and LEN_W default constants, and the DRAIN length constant (2).
REQ-036 Word generation and exp_sum accumulation SHALL live in sub-module acc_drv_gen (inputs load, advance, base, step; outputs word, sum).
REQ-037 The FSM and the checker SHALL live in acc_driver.

Verification
REQ-038 base=1, step=1, len=4, no hold -> acc_data_in = 1,2,3,4 in cycles 2..5; exp_sum=10; done in cycle 8; with check, accumulator data_out=10 and match=1.
REQ-039 base=0xFFFFFFFF, step=1, len=2 -> words 0xFFFFFFFF then 0x00000000; exp_sum=0xFFFFFFFF (wrap).
REQ-040 base=5, step=0, len=3, hold=1 in cycles 3 and 4 -> acc_enable pattern 1,0,0,1,1; exp_sum=15; done in cycle 9.
REQ-041 len=0 -> acc_clear in cycle 1, no acc_enable, exp_sum=0, done in cycle 4.
REQ-042 start re-pulsed in cycle 3 of a len=4 burst -> ignored; exactly one done, in cycle 8.
REQ-043 reset asserted in cycle 4 of a len=8 burst -> IDLE next cycle, all outputs 0, no done; a fresh start then completes normally.
